mem_access_ctrl: RTL
====================

// Module: mem_access_ctrl
// PURPOSE
//  Two-requester access controller for the 8-bit memory block.
//  Arbitrates read/write requests and sequences each one as an ADDR phase then a DATA phase.
//  In each phase it drives rd_en/wr_en and the register-path or buffer-path enables.
//  Returns read data and a completion strobe to the winning requester.
// PARAMETERS
//  AW        8  address width
//  DW        8  data width
//  PHASE_CYC 1  cycles each of ADDR and DATA is held (>=1)
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      asynchronous, active-high reset
//  req_valid    in   2      request pending, one bit per requester
//  req_wr       in   2      1=write, 0=read, per requester
//  req_path     in   2      0=register path, 1=buffer path, per requester
//  req_addr     in   2*AW   address; requester i at [i*AW +: AW]
//  req_wdata    in   2*DW   write data; requester i at [i*DW +: DW]
//  req_ready    out  2      1-cycle accept pulse to the granted requester
//  rsp_valid    out  1      1-cycle completion strobe
//  rsp_id       out  1      requester that owns rsp_valid
//  rsp_rdata    out  DW     read data; 0 for writes
//  mem_rdata    in   DW     data_out from the memory
//  mem_addr     out  AW     address to the memory (addr_in)
//  mem_wdata    out  DW     write data to the memory (data_in)
//  rd_en/wr_en  out  1 each memory read/write strobes
//  addrreg_en, addrbuff_en, datareg_en, databuff_en  out 1 each: path enables
//  busy         out  1      state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; RR pointer=0. Reset mid-transaction aborts it with no rsp.
//  - FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant one requester and pulse its req_ready for that cycle.
//    Latch wr, path, addr and wdata. Next state is ADDR.
//  - ADDR: held PHASE_CYC cycles. mem_addr=latched addr; rd_en=!wr, wr_en=wr.
//    addrreg_en=!path, addrbuff_en=path. Data enables are 0.
//  - DATA: held PHASE_CYC cycles. rd_en/wr_en unchanged; datareg_en=!path, databuff_en=path.
//    Address enables are 0. mem_wdata=latched wdata on writes, else 0.
//    Reads sample mem_rdata on the last DATA cycle.
//  - RESP: rsp_valid=1 for one cycle with rsp_id and rsp_rdata. All memory strobes are 0.
//  - Phase counter is ceil(log2(PHASE_CYC+1)) bits, clears on each phase entry. No wrap.
//  - Access latency is fixed: accept to rsp_valid = 2*PHASE_CYC+1 cycles.
//  - Never more than one transaction in flight. req_valid while busy is ignored.
//    Requesters must hold req_valid until req_ready.
//  - Never asserts reg and buff enables, or rd_en and wr_en, in the same cycle.
//  - Simultaneous req_valid=2'b11: resolved by the arbitration rule below.
//  - A requester dropping req_valid after accept does not cancel its transaction.
// CONFIGURATION
//  MEM_CTRL_RR_EN defined:
//    Round-robin arbitration. A 1-bit pointer names the preferred requester.
//    After each grant the pointer moves to the other requester.
//  MEM_CTRL_RR_EN undefined:
//    Fixed priority: requester 0 always wins. No pointer flop.
// TESTING
//  1 Reset asserted mid-DATA -> all outputs 0 immediately; no rsp_valid after release.
//  2 Req0 write, path=0, addr=0x55, wdata=0xAA
//    -> req_ready=01; ADDR: wr_en=1, addrreg_en=1, mem_addr=0x55.
//    -> DATA: datareg_en=1, mem_wdata=0xAA; rsp_valid with id=0 at cycle 3 (PHASE_CYC=1).
//  3 Req1 read, path=1, addr=0xF0, mem_rdata=0x0F
//    -> addrbuff_en then databuff_en with rd_en=1; rsp_id=1, rsp_rdata=0x0F.
//  4 req_valid=11 held for two transactions
//    -> RR_EN: grants 0 then 1; without RR_EN: grants 0 then 0.
//  5 PHASE_CYC=3 read -> ADDR held 3 cycles, DATA held 3 cycles; rsp_valid 7 cycles after accept.
//  6 req_valid asserted while busy -> no req_ready until RESP completes; accepted next IDLE cycle.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Two-requester access controller for the 8-bit memory block. It arbitrates
//   read/write requests and runs each accepted request as an ADDR phase and
//   then a DATA phase. Each phase lasts PHASE_CYC cycles. A single RESP cycle
//   follows, which returns read data and a completion strobe to the owner.
//   Only one transaction is in flight at a time. Requests seen while busy are
//   ignored until the controller is back in IDLE.
//
// Configuration macro:
//   MEM_CTRL_RR_EN  defined   -> round-robin arbitration with a 1-bit pointer
//                   undefined -> fixed priority, requester 0 always wins
//
// Parameters:
//   AW         address width
//   DW         data width
//   PHASE_CYC  cycles each of ADDR and DATA is held (>= 1)
//
// Ports:
//   clk, rst                      clock (rising edge), async active-high reset
//   req_valid/req_wr/req_path     per-requester request, direction, path select
//   req_addr/req_wdata            packed per-requester address / write data
//   req_ready                     1-cycle accept pulse to the granted requester
//   rsp_valid/rsp_id/rsp_rdata    completion strobe, owner, read data (0 on wr)
//   mem_rdata                     data_out from the memory
//   mem_addr/mem_wdata            addr_in / data_in to the memory
//   rd_en/wr_en                   memory strobes
//   addrreg_en/addrbuff_en        address-phase path enables
//   datareg_en/databuff_en        data-phase path enables
//   busy                          controller is not in IDLE
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
    parameter int AW        = 8,
    parameter int DW        = 8,
    parameter int PHASE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      req_valid,
    input  logic [1:0]      req_wr,
    input  logic [1:0]      req_path,
    input  logic [2*AW-1:0] req_addr,
    input  logic [2*DW-1:0] req_wdata,
    output logic [1:0]      req_ready,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [DW-1:0]   rsp_rdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic            rd_en,
    output logic            wr_en,
    output logic            addrreg_en,
    output logic            addrbuff_en,
    output logic            datareg_en,
    output logic            databuff_en,
    output logic            busy
);

    localparam int CW = (PHASE_CYC < 1) ? 1 : $clog2(PHASE_CYC + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Transaction context captured at accept time
    logic            wr_q, wr_d;
    logic            path_q, path_d;
    logic            id_q, id_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;

    logic            gnt_id;
    logic            accept;
    logic            phase_last;

    assign accept     = (state_q == S_IDLE) && (|req_valid);
    assign phase_last = (cnt_q == LAST_CNT);

    // -------------------------------------------------------------------------
    // Arbitration
    // -------------------------------------------------------------------------
`ifdef MEM_CTRL_RR_EN
    logic ptr_q, ptr_d;

    // With a single requester pending it wins outright. The pointer only
    // breaks ties when both are pending.
    always_comb begin
        if (req_valid == 2'b11) begin
            gnt_id = ptr_q;
        end else begin
            gnt_id = ~req_valid[0];
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = ~gnt_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        gnt_id = ~req_valid[0];
    end
`endif

    // -------------------------------------------------------------------------
    // Next-state and context capture
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        path_d  = path_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    id_d    = gnt_id;
                    wr_d    = req_wr[gnt_id];
                    path_d  = req_path[gnt_id];
                    addr_d  = gnt_id ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
                    wdata_d = gnt_id ? req_wdata[2*DW-1:DW] : req_wdata[DW-1:0];
                end
            end
            S_ADDR: begin
                if (phase_last) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (phase_last) begin
                    state_d = S_RESP;
                    cnt_d   = '0;
                    // The memory output is only trusted on the final DATA cycle
                    rdata_d = wr_q ? '0 : mem_rdata;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Context registers are only observed through state-qualified outputs,
    // so they need no reset.
    always_ff @(posedge clk) begin
        wr_q    <= wr_d;
        path_q  <= path_d;
        id_q    <= id_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdata_q <= rdata_d;
    end

    // -------------------------------------------------------------------------
    // Outputs, decoded from state so an async reset clears them at once
    // -------------------------------------------------------------------------
    always_comb begin
        req_ready   = 2'b00;
        rsp_valid   = 1'b0;
        rsp_id      = 1'b0;
        rsp_rdata   = '0;
        mem_addr    = '0;
        mem_wdata   = '0;
        rd_en       = 1'b0;
        wr_en       = 1'b0;
        addrreg_en  = 1'b0;
        addrbuff_en = 1'b0;
        datareg_en  = 1'b0;
        databuff_en = 1'b0;
        busy        = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // Gated so that requests presented during reset see no accept
                if (accept && !rst) begin
                    req_ready = gnt_id ? 2'b10 : 2'b01;
                end
            end
            S_ADDR: begin
                mem_addr    = addr_q;
                rd_en       = ~wr_q;
                wr_en       = wr_q;
                addrreg_en  = ~path_q;
                addrbuff_en = path_q;
            end
            S_DATA: begin
                // Address stays on the bus so the memory can complete the access
                mem_addr    = addr_q;
                mem_wdata   = wr_q ? wdata_q : '0;
                rd_en       = ~wr_q;
                wr_en       = wr_q;
                datareg_en  = ~path_q;
                databuff_en = path_q;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_rdata = rdata_q;
            end
            default: begin
            end
        endcase
    end

endmodule
